// File: rtl/fetch_ifid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ifid_pkg
//  Description : Shared RV32I pipeline types and constants for the fetch
//                stage and the IF/ID register.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_ifid_pkg;

    // Fetch control states
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_PEND = 2'd1,
        ST_HALTED    = 2'd2
    } fetch_state_t;

    // addi x0,x0,0 used as a pipeline bubble
    localparam logic [31:0] C_NOP_INSTR   = 32'h0000_0013;
    localparam logic [6:0]  C_HALT_OPCODE = 7'b1111111;

    // Opcode field location within an instruction word
    localparam int C_OPCODE_MSB = 6;
    localparam int C_OPCODE_LSB = 0;

    // IF/ID pipeline register contents, shared with the decode stage
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    // True when the instruction's opcode field equals the given opcode
    function automatic logic f_opcode_is(input logic [31:0] instr,
                                         input logic [6:0]  opcode);
        return instr[C_OPCODE_MSB:C_OPCODE_LSB] == opcode;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ifid_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ifid_pc_reg
//  Description : Program counter with reset, hold, redirect and +4 advance.
//                Redirect wins over hold; redirect targets are word-aligned.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_ifid_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_hold,
    input  logic        i_redirect,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;

    // PC update: redirect to aligned target, hold, or step to next word
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= i_target & ~32'h0000_0003;
        end else if (!i_hold) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_ifid.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ifid
//  Description : RV32I instruction-fetch stage and IF/ID pipeline register.
//                Handles stall, branch flush, and freezes fetch once a halt
//                instruction has been committed into IF/ID.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_ifid
    import fetch_ifid_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ADDR_W      = 8,
    parameter logic [31:0] NOP_INSTR   = C_NOP_INSTR,
    parameter logic [6:0]  HALT_OPCODE = C_HALT_OPCODE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       imem_instr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       IF_ID_pc,
    output logic [31:0]       IF_ID_instr,
    output logic              IF_ID_valid,
    output logic              halted
);

    fetch_state_t r_state;
    if_id_t       r_if_id;
    logic         r_halted;

    logic [31:0]  w_pc;
    logic         w_pc_hold;
    logic         w_pc_redirect;
    logic         w_fetch_is_halt;

    assign w_fetch_is_halt = f_opcode_is(imem_instr, HALT_OPCODE);

    // PC control: only RUN advances; flush redirects in RUN and HALT_PEND
    always_comb begin
        w_pc_hold     = 1'b1;
        w_pc_redirect = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (flush) begin
                    w_pc_redirect = 1'b1;
                end else if (!stall && !w_fetch_is_halt) begin
                    w_pc_hold = 1'b0;
                end
            end
            ST_HALT_PEND: begin
                w_pc_redirect = flush;
            end
            default: begin
                w_pc_hold = 1'b1;
            end
        endcase
    end

    fetch_ifid_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_hold     (w_pc_hold),
        .i_redirect (w_pc_redirect),
        .i_target   (branch_target),
        .o_pc       (w_pc)
    );

    // IF/ID capture and halt state machine
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= ST_RUN;
            r_if_id.pc     <= 32'h0000_0000;
            r_if_id.instr  <= NOP_INSTR;
            r_if_id.valid  <= 1'b0;
            r_halted       <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (flush) begin
                        r_if_id.pc    <= 32'h0000_0000;
                        r_if_id.instr <= NOP_INSTR;
                        r_if_id.valid <= 1'b0;
                    end else if (!stall) begin
                        r_if_id.pc    <= w_pc;
                        r_if_id.instr <= imem_instr;
                        r_if_id.valid <= 1'b1;
                        if (w_fetch_is_halt) begin
                            r_state <= ST_HALT_PEND;
                        end
                    end
                end
                ST_HALT_PEND: begin
                    // The halt may be on a wrong path, so a flush still cancels it
                    if (flush) begin
                        r_if_id.pc    <= 32'h0000_0000;
                        r_if_id.instr <= NOP_INSTR;
                        r_if_id.valid <= 1'b0;
                        r_state       <= ST_RUN;
                    end else if (!stall) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign imem_addr   = w_pc[ADDR_W+1:2];
    assign IF_ID_pc    = r_if_id.pc;
    assign IF_ID_instr = r_if_id.instr;
    assign IF_ID_valid = r_if_id.valid;
    assign halted      = r_halted;

endmodule
`default_nettype wire

// File: doc/fetch_ifid.md
Name: fetch_ifid

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the RV32I 5-stage pipeline.
- Sits directly upstream of the load-use hazard detector and consumes its stall output.
- Holds the PC, drives the instruction-memory address and captures fetched instructions into IF/ID.
- Honours stall and branch flush; freezes fetch once a halt instruction (opcode 7'b1111111) is committed into IF/ID.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
ADDR_W, 8, instruction-memory word-address width
NOP_INSTR, 32'h0000_0013, bubble inserted on flush/reset (addi x0,x0,0)
HALT_OPCODE, 7'b1111111, opcode that stops fetch

Ports:
clk  input  1  pipeline clock, all state on rising edge
reset_n  input  1  synchronous reset, active-low
stall  input  1  from hazard detection; hold PC and IF/ID
flush  input  1  branch/jump taken in EX; redirect PC, squash IF/ID
branch_target  input  32  redirect PC, valid when flush=1
imem_instr  input  32  combinational instruction-memory read data for imem_addr
imem_addr  output  ADDR_W  word address = pc[ADDR_W+1:2]
IF_ID_pc  output  32  PC of instruction in IF/ID
IF_ID_instr  output  32  instruction in IF/ID
IF_ID_valid  output  1  IF/ID holds a real (non-bubble) instruction
halted  output  1  fetch permanently frozen

Behaviour:
- One clock, synchronous active-low reset; reset_n=0 overrides everything, including mid-halt.
- Reset values: pc=RESET_PC, IF_ID_pc=0, IF_ID_instr=NOP_INSTR, IF_ID_valid=0, halted=0, state=RUN.
- imem_addr is combinational from pc; fetch latency is 1 cycle (pc → IF/ID on the next edge).
- States: RUN, HALT_PEND, HALTED.
- RUN, priority flush > stall > advance:
  - flush: pc<=branch_target with bits[1:0] forced to 0; IF_ID_instr<=NOP_INSTR; IF_ID_valid<=0; IF_ID_pc<=0. Applies even when stall=1.
  - stall (no flush): pc and all IF/ID outputs hold.
  - advance: IF_ID_instr<=imem_instr; IF_ID_pc<=pc; IF_ID_valid<=1. If imem_instr[6:0]==HALT_OPCODE, pc holds and state<=HALT_PEND; otherwise pc<=pc+4 (mod 2^32, wraps silently).
- HALT_PEND (halt instruction sits in IF/ID, may still be wrong-path):
  - flush: squash exactly as in RUN and return to RUN.
  - stall: hold.
  - otherwise: state<=HALTED, halted<=1.
  - pc never advances in this state.
- HALTED:
  - pc and IF/ID frozen; stall and flush ignored; halted=1 until reset.
  - Downstream hazard detection independently sees the halt opcode and keeps stall high.
- No imem access is suppressed; imem_addr stays valid in every state.

Decomposition:
- Shared pipeline package: state enum (RUN/HALT_PEND/HALTED), NOP_INSTR and HALT_OPCODE constants, opcode field slice constant [6:0], and an if_id_t struct {pc, instr, valid} reused by the ID stage.
- One natural sub-module: pc_reg (PC register with reset, hold, redirect and +4 increment).
- The IF/ID register and state machine stay in the top.

Test Plan:
- Reset then straight-line code at words 0..3 with stall=flush=0 → imem_addr 0,1,2,3 on successive cycles; IF_ID_pc 0,4,8 lagging by one cycle; IF_ID_valid=1 from cycle 1.
- stall=1 for 2 cycles while pc=8 → pc, IF_ID_pc=4 and IF_ID_instr unchanged for 2 cycles, then fetch resumes at 8.
- flush=1 with stall=1, branch_target=32'h0000_0043 → next pc=32'h40, IF_ID_instr=32'h13, IF_ID_valid=0.
- Halt instruction 32'h0000_007F at word 5 → IF_ID_instr=0x7F, pc stays 20, halted=1 one cycle later; flush pulses afterwards are ignored.
- Halt fetched, then flush to 0x100 in the HALT_PEND cycle → returns to RUN, pc=0x100, halted stays 0.
- reset_n=0 while HALTED → pc=RESET_PC, halted=0, IF_ID_instr=0x13, IF_ID_valid=0 on the next edge.
- pc=32'hFFFF_FFFC advancing → pc wraps to 0, no error.
